wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (writeback) stage of the five-stage pipeline; directly downstream of the memory stage.
- Latches the MEM→WB payload and commits architectural state:
  - regfile write;
  - CSR read-replace and write;
  - exception and ertn commit.
- Raises the pipeline-wide flush (wb_ex / ertn_flush) that empties all earlier stages.
- Exports a writeback-forwarding bundle to the ID stage.

Parameters:
- PC_W, 32, PC/data width.
- EXC_W, 82, width of the exception/CSR bundle carried in ms2ws_bus.
- SYS_ECODE, 6'h0B, ecode committed for syscall.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- ws_allowin  out  1  WB can accept a MEM beat this cycle.
- ms2ws_valid  in  1  MEM beat valid.
- ms2ws_bus  in  114  {pc[31:0], exc[81:0]}.
- ms_rf_zip  in  39  {csr_re, rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  32  regfile write data.
- csr_re  out  1  CSR read strobe.
- csr_num  out  14  CSR index.
- csr_rvalue  in  32  CSR read data, combinational.
- csr_we  out  1  CSR write enable.
- csr_wmask  out  32  CSR write mask.
- csr_wvalue  out  32  CSR write value.
- wb_ex  out  1  exception commit; flushes the pipeline.
- wb_ecode  out  6  exception code.
- wb_pc  out  32  PC of the committing instruction (ERA source).
- ertn_flush  out  1  ertn commit.
- ws_rf_zip  out  38  {rf_we&valid, rf_waddr, rf_wdata}, forwarding to ID.

Behaviour:
- exc layout:
  - [81:68] csr_num
  - [67:36] csr_wmask
  - [35:4] csr_wvalue
  - [3] csr_we
  - [2] syscall
  - [1] ertn
  - [0] reserved, ignored.
- Handshake:
  - ws_ready_go = 1.
  - ws_allowin = ~ws_valid | ws_ready_go.
  - A beat is accepted when ms2ws_valid & ws_allowin.
- ws_valid update, in priority order:
  - reset → 0;
  - else (wb_ex | ertn_flush) → 0;
  - else if ws_allowin → ms2ws_valid.
- Payload registers (pc, exc, rf fields):
  - load only on accept;
  - cleared to 0 on reset;
  - held otherwise.
- Latency: one cycle; a beat accepted at edge N commits during cycle N.
- Derived outputs:
  - ex = ws_valid & syscall; ertn = ws_valid & ertn & ~syscall.
  - wb_ex = ex; wb_ecode = ex ? SYS_ECODE : 0; wb_pc = ws_pc.
  - ertn_flush = ertn.
  - rf_we = ws_valid & rf_we_q & ~ex.
  - rf_wdata = csr_re_q ? csr_rvalue : rf_wdata_q.
  - csr_re = ws_valid & csr_re_q.
  - csr_we = ws_valid & csr_we_q & ~ex.
  - csr_num, csr_wmask and csr_wvalue pass through unconditionally.
- Flush:
  - wb_ex/ertn_flush is a single-cycle pulse per committing instruction; ws_valid drops the next cycle.
  - A beat offered during a flush cycle is not captured: the valid-clear has priority. Earlier stages are flushed by the same signal.
- Reset mid-operation: all outputs 0 in the cycle after the reset edge; ws_allowin = 1.
- Simultaneous csr_we and csr_re on the same instruction (csrxchg): the old value is read into rf_wdata and the CSR is written on the same edge.
- ertn together with syscall: syscall has priority.

Optional Feature:
- Macro WB_DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0] = {4{rf_we}}, debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0], all mirroring the committed values.
- Undefined: the ports are absent; no other behaviour change.

Decomposition:
- Shared package/header (macro.h) holds:
  - MS2WS_LEN = 114;
  - exc bit-field index constants;
  - SYS_ECODE;
  - ecode constants.
- No sub-module; the block is a single flat module.

Test Plan:
- Normal writeback: accept rf_we=1, waddr=5, wdata=0x12345678, pc=0x1C000010 → same cycle rf_we=1, waddr=5, wdata=0x12345678; next cycle rf_we=0 if no new beat.
- csrrd: csr_re=1, csr_num=0x0C, csr_rvalue=0xDEADBEEF → rf_wdata=0xDEADBEEF, csr_we=0.
- csrxchg: csr_we=1, wmask=0xFFFF0000, wvalue=0xAAAA5555, csr_re=1 → csr_we=1 with those values; rf_wdata = old csr_rvalue.
- Syscall: syscall=1, rf_we=1, pc=0x1C000040:
  - cycle N: wb_ex=1, wb_ecode=0x0B, wb_pc=0x1C000040, rf_we=0, csr_we=0;
  - cycle N+1: ws_valid=0, and a beat offered in cycle N is dropped.
- ertn: ertn=1 → ertn_flush pulses for 1 cycle, wb_ex=0; ertn+syscall together → only wb_ex.
- Reset: assert resetn=0 mid-stream with ws_valid=1 → next cycle all outputs 0, ws_allowin=1; back-to-back beats resume after deassertion.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: bus lengths, exc bit-field
// layout of the MEM->WB payload, and exception codes.
package wb_stage_pkg;

    localparam int MS2WS_LEN = 114;   // {pc[31:0], exc[81:0]}
    localparam int MS_RF_LEN = 39;    // {csr_re, rf_we, rf_waddr[4:0], rf_wdata[31:0]}
    localparam int WS_RF_LEN = 38;    // {rf_we, rf_waddr[4:0], rf_wdata[31:0]}

    // exc bit-field positions inside ms2ws_bus[81:0]
    localparam int EXC_CSR_NUM_HI   = 81;
    localparam int EXC_CSR_NUM_LO   = 68;
    localparam int EXC_CSR_WMASK_HI = 67;
    localparam int EXC_CSR_WMASK_LO = 36;
    localparam int EXC_CSR_WVAL_HI  = 35;
    localparam int EXC_CSR_WVAL_LO  = 4;
    localparam int EXC_CSR_WE       = 3;
    localparam int EXC_SYSCALL      = 2;
    localparam int EXC_ERTN         = 1;
    localparam int EXC_RSVD         = 0;

    // Exception codes
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Ecode committed for syscall unless the stage overrides it
    localparam logic [5:0] SYS_ECODE_DEFAULT = ECODE_SYS;

    // Structured view of exc[81:0]; field order matches the bit-field constants
    typedef struct packed {
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        csr_we;
        logic        syscall;
        logic        ertn;
        logic        rsvd;
    } exc_t;

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM->WB beat, commits regfile/CSR writes,
// raises the pipeline flush for syscall/ertn, and forwards the writeback
// result to ID. Optional macro WB_DEBUG_TRACE_EN adds debug trace outputs.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int         PC_W      = 32,
    parameter int         EXC_W     = 82,
    parameter logic [5:0] SYS_ECODE = SYS_ECODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  ws_allowin,
    input  logic                  ms2ws_valid,
    input  logic [PC_W+EXC_W-1:0] ms2ws_bus,
    input  logic [PC_W+6:0]       ms_rf_zip,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [PC_W-1:0]       rf_wdata,
    output logic                  csr_re,
    output logic [13:0]           csr_num,
    input  logic [31:0]           csr_rvalue,
    output logic                  csr_we,
    output logic [31:0]           csr_wmask,
    output logic [31:0]           csr_wvalue,
    output logic                  wb_ex,
    output logic [5:0]            wb_ecode,
    output logic [PC_W-1:0]       wb_pc,
    output logic                  ertn_flush,
    output logic [PC_W+5:0]       ws_rf_zip
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]       debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [PC_W-1:0]       debug_wb_rf_wdata
`endif
);

    // Handshake / control
    logic ws_ready_go;
    logic ws_valid_q, ws_valid_d;
    logic accept;
    logic ex, ertn, flush;

    // Latched payload
    logic [PC_W-1:0] pc_q;
    logic [13:0]     csr_num_q;
    logic [31:0]     csr_wmask_q;
    logic [31:0]     csr_wvalue_q;
    logic            csr_we_q;
    logic            syscall_q;
    logic            ertn_q;
    logic            csr_re_q;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [PC_W-1:0] rf_wdata_q;

    // Decoded view of the incoming beat
    exc_t            exc_in;
    logic [PC_W-1:0] ms_pc;
    logic            unused_exc_rsvd;

    assign exc_in          = exc_t'(ms2ws_bus[EXC_W-1:0]);
    assign ms_pc           = ms2ws_bus[PC_W+EXC_W-1 -: PC_W];
    assign unused_exc_rsvd = exc_in.rsvd;

    // WB always completes in its single cycle, so it can always take a new beat
    assign ws_ready_go = 1'b1;
    assign ws_allowin  = ~ws_valid_q | ws_ready_go;
    assign accept      = ms2ws_valid & ws_allowin;

    // syscall wins over ertn when both are set on one instruction
    assign ex    = ws_valid_q & syscall_q;
    assign ertn  = ws_valid_q & ertn_q & ~syscall_q;
    assign flush = ex | ertn;

    // Next-state for ws_valid: a committing flush empties WB ahead of any new beat
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ws_valid_d = ws_valid_q;
        if (flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms2ws_valid;
        end
    end

    // Valid register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (!resetn) begin
            ws_valid_q <= 1'b0;
        end else begin
            ws_valid_q <= ws_valid_d;
        end
    end

    // Payload registers: capture on accept, hold otherwise
    always_ff @(posedge clk) begin
        // NOTE: payload is reset too, because csr_num/wmask/wvalue and wb_pc pass through ungated and must read 0 after reset.
        if (!resetn) begin
            pc_q         <= '0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            csr_we_q     <= 1'b0;
            syscall_q    <= 1'b0;
            ertn_q       <= 1'b0;
            csr_re_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else if (accept) begin
            pc_q         <= ms_pc;
            csr_num_q    <= exc_in.csr_num;
            csr_wmask_q  <= exc_in.csr_wmask;
            csr_wvalue_q <= exc_in.csr_wvalue;
            csr_we_q     <= exc_in.csr_we;
            syscall_q    <= exc_in.syscall;
            ertn_q       <= exc_in.ertn;
            csr_re_q     <= ms_rf_zip[PC_W+6];
            rf_we_q      <= ms_rf_zip[PC_W+5];
            rf_waddr_q   <= ms_rf_zip[PC_W+4:PC_W];
            rf_wdata_q   <= ms_rf_zip[PC_W-1:0];
        end
    end

    // Architectural commit: an excepting instruction writes neither regfile nor CSR
    assign rf_we    = ws_valid_q & rf_we_q & ~ex;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = csr_re_q ? csr_rvalue : rf_wdata_q;

    // CSR access; csrxchg reads the old value and writes the new one on the same edge
    assign csr_re     = ws_valid_q & csr_re_q;
    assign csr_we     = ws_valid_q & csr_we_q & ~ex;
    assign csr_num    = csr_num_q;
    assign csr_wmask  = csr_wmask_q;
    assign csr_wvalue = csr_wvalue_q;

    // Pipeline-wide flush signals
    assign wb_ex      = ex;
    assign wb_ecode   = ex ? SYS_ECODE : 6'h00;
    assign wb_pc      = pc_q;
    assign ertn_flush = ertn;

    // Forwarding bundle to ID carries the final (possibly CSR-sourced) data
    assign ws_rf_zip = {ws_valid_q & rf_we_q, rf_waddr_q, rf_wdata};

`ifdef WB_DEBUG_TRACE_EN
    // Commit trace mirrors
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected commit bundles,
// pushed when a beat is offered and popped in its commit cycle.
module tb_wb_stage;

    logic         clk;
    logic         resetn;
    logic         ws_allowin;
    logic         ms2ws_valid;
    logic [113:0] ms2ws_bus;
    logic [38:0]  ms_rf_zip;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         wb_ex;
    logic [5:0]   wb_ecode;
    logic [31:0]  wb_pc;
    logic         ertn_flush;
    logic [37:0]  ws_rf_zip;

    wb_stage dut (
        .clk         (clk),
        .resetn      (resetn),
        .ws_allowin  (ws_allowin),
        .ms2ws_valid (ms2ws_valid),
        .ms2ws_bus   (ms2ws_bus),
        .ms_rf_zip   (ms_rf_zip),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .csr_re      (csr_re),
        .csr_num     (csr_num),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .wb_ex       (wb_ex),
        .wb_ecode    (wb_ecode),
        .wb_pc       (wb_pc),
        .ertn_flush  (ertn_flush),
        .ws_rf_zip   (ws_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        csr_we;
        logic        syscall;
        logic        ertn;
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } beat_t;

    // Commit bundle: {rf_we, rf_waddr, rf_wdata, csr_re, csr_we, csr_num,
    //                 csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_pc, ertn_flush}
    typedef logic [157:0] commit_t;

    commit_t sb[$];
    int      total = 0;
    int      bad   = 0;

    function automatic commit_t observed();
        return {rf_we, rf_waddr, rf_wdata, csr_re, csr_we, csr_num,
                csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_pc, ertn_flush};
    endfunction

    // Expected commit for a beat, written from the stage's commit rules
    function automatic commit_t expect_of(input beat_t b, input logic [31:0] rv);
        logic        e_ex;
        logic [31:0] e_data;
        e_ex   = b.syscall;
        e_data = b.csr_re ? rv : b.wdata;
        return {b.rf_we & ~e_ex, b.waddr, e_data, b.csr_re, b.csr_we & ~e_ex,
                b.csr_num, b.wmask, b.wvalue, e_ex, (e_ex ? 6'h0B : 6'h00),
                b.pc, b.ertn & ~e_ex};
    endfunction

    function automatic beat_t blank_beat();
        beat_t b;
        b.pc = 32'h0; b.csr_num = 14'h0; b.wmask = 32'h0; b.wvalue = 32'h0;
        b.csr_we = 1'b0; b.syscall = 1'b0; b.ertn = 1'b0; b.csr_re = 1'b0;
        b.rf_we = 1'b0; b.waddr = 5'h0; b.wdata = 32'h0;
        return b;
    endfunction

    // Drive a beat for the next edge; record it in the scoreboard when it should commit
    task automatic offer(input beat_t b, input logic [31:0] rv, input bit expect_commit);
        @(negedge clk);
        ms2ws_valid = 1'b1;
        ms2ws_bus   = {b.pc, b.csr_num, b.wmask, b.wvalue, b.csr_we, b.syscall, b.ertn, 1'b0};
        ms_rf_zip   = {b.csr_re, b.rf_we, b.waddr, b.wdata};
        csr_rvalue  = rv;
        if (expect_commit) sb.push_back(expect_of(b, rv));
    endtask

    task automatic idle();
        @(negedge clk);
        ms2ws_valid = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        commit_t got;
        resetn = 1'b0;
        ms2ws_valid = 1'b0; ms2ws_bus = '0; ms_rf_zip = '0; csr_rvalue = 32'h5A5A5A5A;
        repeat (2) settle();
        got = observed();
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", got); end
        total++;
        if (ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin: got %b want 1", ws_allowin); end
        total++;
        if (ws_rf_zip !== '0) begin bad++; $display("FAIL reset_fwd: got %h want 0", ws_rf_zip); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_normal();
        beat_t   b;
        commit_t e, got;
        b = blank_beat();
        b.pc = 32'h1C000010; b.rf_we = 1'b1; b.waddr = 5'd5; b.wdata = 32'h12345678;
        offer(b, 32'h0, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL normal_commit: got %h want %h", got, e); end
        total++;
        if (ws_rf_zip !== {1'b1, 5'd5, 32'h12345678})
            begin bad++; $display("FAIL normal_fwd: got %h want %h", ws_rf_zip, {1'b1, 5'd5, 32'h12345678}); end
        idle();
        settle();
        total++;
        if (rf_we !== 1'b0) begin bad++; $display("FAIL normal_idle_rf_we: got %b want 0", rf_we); end
        total++;
        if (ws_rf_zip[37] !== 1'b0) begin bad++; $display("FAIL normal_idle_fwd_we: got %b want 0", ws_rf_zip[37]); end
    endtask

    task automatic test_csrrd();
        beat_t   b;
        commit_t e, got;
        b = blank_beat();
        b.pc = 32'h1C000020; b.csr_re = 1'b1; b.csr_num = 14'h000C;
        b.rf_we = 1'b1; b.waddr = 5'd7; b.wdata = 32'h00001111;
        offer(b, 32'hDEADBEEF, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL csrrd_commit: got %h want %h", got, e); end
        total++;
        if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL csrrd_wdata: got %h want deadbeef", rf_wdata); end
        total++;
        if (csr_we !== 1'b0) begin bad++; $display("FAIL csrrd_csr_we: got %b want 0", csr_we); end
    endtask

    task automatic test_csrxchg();
        beat_t   b;
        commit_t e, got;
        b = blank_beat();
        b.pc = 32'h1C000030; b.csr_re = 1'b1; b.csr_we = 1'b1; b.csr_num = 14'h0006;
        b.wmask = 32'hFFFF0000; b.wvalue = 32'hAAAA5555;
        b.rf_we = 1'b1; b.waddr = 5'd12; b.wdata = 32'h0;
        offer(b, 32'h0BADF00D, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL csrxchg_commit: got %h want %h", got, e); end
        total++;
        if ({csr_we, csr_wmask, csr_wvalue} !== {1'b1, 32'hFFFF0000, 32'hAAAA5555})
            begin bad++; $display("FAIL csrxchg_write: got %b %h %h want 1 ffff0000 aaaa5555", csr_we, csr_wmask, csr_wvalue); end
        total++;
        if (rf_wdata !== 32'h0BADF00D) begin bad++; $display("FAIL csrxchg_old: got %h want 0badf00d", rf_wdata); end
    endtask

    task automatic test_syscall();
        beat_t   b, late;
        commit_t e, got;
        b = blank_beat();
        b.pc = 32'h1C000040; b.syscall = 1'b1; b.rf_we = 1'b1; b.waddr = 5'd3;
        b.wdata = 32'hCAFE0001; b.csr_we = 1'b1; b.csr_num = 14'h0001; b.wvalue = 32'h1;
        offer(b, 32'h0, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL syscall_commit: got %h want %h", got, e); end
        total++;
        if ({wb_ex, wb_ecode, wb_pc, rf_we, csr_we} !== {1'b1, 6'h0B, 32'h1C000040, 1'b0, 1'b0})
            begin bad++; $display("FAIL syscall_fields: got %b %h %h %b %b want 1 0b 1c000040 0 0", wb_ex, wb_ecode, wb_pc, rf_we, csr_we); end
        // Beat offered during the flush cycle must be dropped
        late = blank_beat();
        late.pc = 32'h1C000044; late.rf_we = 1'b1; late.waddr = 5'd9; late.wdata = 32'h99999999;
        offer(late, 32'h0, 1'b0);
        settle();
        total++;
        if ({rf_we, ws_rf_zip[37], wb_ex, ertn_flush, csr_re, csr_we} !== 6'b0)
            begin bad++; $display("FAIL syscall_drop: got we=%b fwd=%b ex=%b ertn=%b cre=%b cwe=%b want all 0",
                                  rf_we, ws_rf_zip[37], wb_ex, ertn_flush, csr_re, csr_we); end
        total++;
        if (ws_allowin !== 1'b1) begin bad++; $display("FAIL syscall_allowin: got %b want 1", ws_allowin); end
        idle();
        settle();
        total++;
        if ({rf_we, wb_ex} !== 2'b00) begin bad++; $display("FAIL syscall_after: got %b want 00", {rf_we, wb_ex}); end
    endtask

    task automatic test_ertn();
        beat_t   b;
        commit_t e, got;
        b = blank_beat();
        b.pc = 32'h1C000050; b.ertn = 1'b1;
        offer(b, 32'h0, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL ertn_commit: got %h want %h", got, e); end
        total++;
        if ({ertn_flush, wb_ex} !== 2'b10) begin bad++; $display("FAIL ertn_pulse: got %b want 10", {ertn_flush, wb_ex}); end
        idle();
        settle();
        total++;
        if (ertn_flush !== 1'b0) begin bad++; $display("FAIL ertn_single: got %b want 0", ertn_flush); end
        // ertn together with syscall: only the exception commits
        b.pc = 32'h1C000060; b.syscall = 1'b1;
        offer(b, 32'h0, 1'b1);
        settle();
        e = sb.pop_front(); got = observed();
        total++;
        if (got !== e) begin bad++; $display("FAIL ertn_sys_commit: got %h want %h", got, e); end
        total++;
        if ({wb_ex, ertn_flush, wb_ecode} !== {1'b1, 1'b0, 6'h0B})
            begin bad++; $display("FAIL ertn_sys_prio: got %b %b %h want 1 0 0b", wb_ex, ertn_flush, wb_ecode); end
        idle();
        settle();
    endtask

    task automatic test_back_to_back();
        beat_t       b;
        commit_t     e, got;
        logic [31:0] rv;
        for (int i = 0; i < 6; i++) begin
            b = blank_beat();
            b.pc     = 32'h1C000100 + 32'(i * 4);
            b.rf_we  = 1'($urandom_range(0, 1));
            b.waddr  = 5'($urandom_range(1, 31));
            b.wdata  = $urandom;
            b.csr_re = 1'(i % 2);
            b.csr_we = 1'($urandom_range(0, 1));
            b.csr_num = 14'($urandom);
            b.wmask  = $urandom;
            b.wvalue = $urandom;
            rv = $urandom;
            offer(b, rv, 1'b1);
            settle();
            e = sb.pop_front(); got = observed();
            total++;
            if (got !== e) begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, got, e); end
        end
        // Reset mid-stream while a beat is committing and another is offered
        @(negedge clk);
        resetn = 1'b0;
        csr_rvalue = 32'h12121212;
        settle();
        got = observed();
        total++;
        if (got !== '0 || ws_rf_zip !== '0)
            begin bad++; $display("FAIL midreset_outputs: got %h fwd %h want 0", got, ws_rf_zip); end
        total++;
        if (ws_allowin !== 1'b1) begin bad++; $display("FAIL midreset_allowin: got %b want 1", ws_allowin); end
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = blank_beat();
            b.pc    = 32'h1C000200 + 32'(i * 4);
            b.rf_we = 1'b1;
            b.waddr = 5'(i + 20);
            b.wdata = 32'hA0000000 + 32'(i);
            offer(b, 32'h0, 1'b1);
            settle();
            e = sb.pop_front(); got = observed();
            total++;
            if (got !== e) begin bad++; $display("FAIL resume_%0d: got %h want %h", i, got, e); end
        end
        idle();
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_normal();
        test_csrrd();
        test_csrxchg();
        test_syscall();
        test_ertn();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
